prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 106 ++++++++++
 tb/tb_prog_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader into a 2^ADDR_W x 8 program memory.
// Holds the CPU in reset until a frame lands with a matching checksum;
// the CPU fetches combinationally through PC.
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] PC,
  output logic [7:0]        program_byte,
  output logic              cpu_reset_n,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] len_q, len_d;     // N-1, index of the last data byte
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        sum_q, sum_d;
  logic              xfer, we;

  logic [7:0] mem [0:DEPTH-1];

  // The loader never back-pressures.
  assign in_ready = 1'b1;
  assign xfer     = in_valid & in_ready;

  // Next-state, length/pointer/checksum updates and write enable.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    sum_d    = sum_q;
    we       = 1'b0;
    if (xfer) begin
      case (state_q)
        ST_IDLE: if (in_data == SYNC_BYTE) state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          len_hi_d = in_data[3:0];
          state_d  = (in_data[7:4] != 4'd0) ? ST_ERROR : ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d   = ADDR_W'({len_hi_q, in_data});
          ptr_d   = '0;
          sum_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          // Sync byte is plain data here.
          we    = 1'b1;
          sum_d = sum_q + in_data;
          // Pointer parks on the last address so a full-size frame never wraps.
          if (ptr_q == len_q) state_d = ST_CHECK;
          else                ptr_d   = ptr_q + 1'b1;
        end
        ST_CHECK: state_d = (in_data == sum_q) ? ST_DONE : ST_ERROR;
        ST_DONE, ST_ERROR: if (in_data == SYNC_BYTE) state_d = ST_LEN_HI;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and status registers; status outputs follow the new state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      cpu_reset_n <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      cpu_reset_n <= (state_d == ST_DONE);
      load_done   <= (state_d == ST_DONE);
      load_error  <= (state_d == ST_ERROR);
    end
  end

  // Program memory write; contents survive reset, but a reset edge blocks the write.
  always_ff @(posedge clock) begin
    if (we && reset) mem[ptr_q] <= in_data;
  end

  // Asynchronous read: a same-cycle write to PC is seen only after the edge.
  assign program_byte = mem[PC];

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frame vectors plus hand sequences for the
// full-size frame, read-during-write and mid-frame reset.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [11:0] PC = 12'h000;
  logic [7:0]  program_byte;
  logic        cpu_reset_n, load_done, load_error;

  int checks = 0;
  int failures = 0;

  prog_loader dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .PC(PC), .program_byte(program_byte),
    .cpu_reset_n(cpu_reset_n), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        done, err, cpu;
    logic        cpb;
    logic [11:0] pc;
    logic [7:0]  pb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] d, input logic done,
                     input logic err, input logic cpu, input logic cpb,
                     input logic [11:0] pc, input logic [7:0] pb);
    vec_t r;
    r.v = v; r.d = d; r.done = done; r.err = err; r.cpu = cpu;
    r.cpb = cpb; r.pc = pc; r.pb = pb;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic done, input logic err, input logic cpu);
    chk({name, " load_done"},   {31'd0, load_done},   {31'd0, done});
    chk({name, " load_error"},  {31'd0, load_error},  {31'd0, err});
    chk({name, " cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, cpu});
    chk({name, " in_ready"},    {31'd0, in_ready},    32'd1);
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [7:0] exp);
    PC = a;
    #1;
    chk(name, {24'd0, program_byte}, {24'd0, exp});
  endtask

  initial begin
    // Good frame with stalls, then DONE holds on idle/non-sync input.
    add(1, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(0, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h02, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h11, 0,0,0, 1, 12'h0, 8'h11);
    add(1, 8'h22, 0,0,0, 1, 12'h1, 8'h22);
    add(0, 8'h33, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h33, 0,0,0, 1, 12'h2, 8'h33);
    add(1, 8'h66, 1,0,1, 1, 12'h1, 8'h22);
    add(0, 8'hA5, 1,0,1, 0, 12'h0, 8'h00);
    add(1, 8'h3C, 1,0,1, 1, 12'h0, 8'h11);
    // Same frame, bad checksum.
    add(1, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h02, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h11, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h22, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h33, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h67, 0,1,0, 1, 12'h2, 8'h33);
    // Junk dropped in ERROR, then one-byte frame whose data is the sync byte.
    add(1, 8'h00, 0,1,0, 0, 12'h0, 8'h00);
    add(1, 8'hFF, 0,1,0, 0, 12'h0, 8'h00);
    add(1, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'hA5, 0,0,0, 1, 12'h0, 8'hA5);
    add(1, 8'hA5, 1,0,1, 1, 12'h0, 8'hA5);
    // Bad LEN_HI, then recovery.
    add(1, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h10, 0,1,0, 0, 12'h0, 8'h00);
    add(1, 8'hA5, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h00, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h07, 0,0,0, 0, 12'h0, 8'h00);
    add(1, 8'h07, 1,0,1, 1, 12'h0, 8'h07);
    add(0, 8'h00, 1,0,1, 1, 12'h1, 8'h22);

    // Reset state.
    reset = 1'b0;
    step(0, 8'h00);
    step(1, 8'hA5);
    chk_outs("reset", 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      PC = vecs[i].pc;
      step(vecs[i].v, vecs[i].d);
      chk_outs(nm, vecs[i].done, vecs[i].err, vecs[i].cpu);
      if (vecs[i].cpb) chk({nm, " program_byte"}, {24'd0, program_byte}, {24'd0, vecs[i].pb});
    end

    // Full 4096-byte frame with random gaps; sum of i[7:0] over 4096 is 0.
    step(1, 8'hA5);
    step(1, 8'h0F);
    step(1, 8'hFF);
    chk_outs("full hdr", 0, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, 8'hA5);
      step(1, i[7:0]);
    end
    chk_outs("full data", 0, 0, 0);
    step(1, 8'h00);
    chk_outs("full chk", 1, 0, 1);
    rd("full mem fff", 12'hFFF, 8'hFF);
    rd("full mem 000", 12'h000, 8'h00);
    rd("full mem 7ab", 12'h7AB, 8'hAB);

    // Mid-frame reset after 2 of 3 bytes; also read-during-write.
    step(1, 8'hA5);
    step(1, 8'h00);
    step(1, 8'h02);
    PC = 12'h000;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    #1;
    chk("rdw old", {24'd0, program_byte}, 32'h00);
    @(posedge clock);
    #1;
    chk("rdw new", {24'd0, program_byte}, 32'h5A);
    step(1, 8'h6B);
    reset = 1'b0;
    step(1, 8'h7C);
    chk_outs("midreset", 0, 0, 0);
    rd("midreset mem0", 12'h000, 8'h5A);
    rd("midreset mem1", 12'h001, 8'h6B);
    rd("midreset mem2", 12'h002, 8'h02);
    reset = 1'b1;
    step(1, 8'h11);
    chk_outs("post reset idle", 0, 0, 0);
    step(1, 8'hA5);
    step(1, 8'h00);
    step(1, 8'h00);
    step(1, 8'h11);
    step(1, 8'h11);
    chk_outs("post reset frame", 1, 0, 1);
    rd("post reset mem0", 12'h000, 8'h11);

    // Reset out of DONE drops the CPU back into reset.
    reset = 1'b0;
    step(0, 8'h00);
    chk_outs("reset from done", 0, 0, 0);
    reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
